adc_sample_framer: RTL
======================

# adc_sample_framer

Front-end stage that deserializes the serial ADC bit stream into 21-bit samples and buffers them for the center/scale stage. Each completed word goes into a small FIFO. Words leave as `x_adc` with a one-cycle `srdyo_o` strobe, paced by the downstream ready input. The block sits directly upstream of `centerScale` and drives its `x_adc` and `srdyi` inputs.

## Interface
- `DEPTH`, 4: FIFO depth in words; power of two, 2..16.
- `WORD_W`, 21: sample width; must equal the `x_adc` width of the downstream stage.
- `clk` input 1: single clock; all logic is rising-edge.
- `GlobalReset` input 1: synchronous, active-high reset.
- `sdi` input 1: serial data bit, MSB first.
- `sdi_vld` input 1: `sdi` is sampled on this cycle.
- `sfi` input 1: frame start; qualifies the first (MSB) bit of a word; meaningful only with `sdi_vld`.
- `drdyi` input 1: downstream ready to accept a sample this cycle.
- `x_adc` output `WORD_W`: current output sample; holds its value between pops.
- `srdyo_o` output 1: one-cycle strobe; `x_adc` is valid on this cycle.
- `overflow_o` output 1: sticky flag; a word was dropped because the FIFO was full.
- `frame_err_o` output 1: one-cycle pulse on a framing error.
- `parity_err_o` output 1: one-cycle pulse on a parity mismatch; tied 0 when parity checking is compiled out.

## Operation
- Receive FSM has two states.
  - IDLE: waits for `sdi_vld & sfi`. On that cycle it loads the bit as the MSB, sets bit count = 1 and goes to SHIFT.
  - SHIFT: on each `sdi_vld`, shifts in `sdi` and increments the count. When count reaches FRAME_W, the word is complete: issue a push request on the next cycle and return to IDLE.
- FRAME_W = `WORD_W`, or `WORD_W`+1 with parity enabled.
- `sdi_vld` low in SHIFT: hold state and count; there is no timeout.
- `sfi` with `sdi_vld` while in SHIFT: discard the partial word, pulse `frame_err_o`, and restart with this bit as MSB (count = 1).
- `sdi_vld & ~sfi` in IDLE: bit ignored, no error.
- Push with FIFO full and no pop in the same cycle: word dropped, `overflow_o` set. `overflow_o` clears only on reset.
- Push with FIFO full and a pop in the same cycle: push accepted; count unchanged.
- Pop occurs when FIFO is non-empty and `drdyi` is high. The popped word is registered to `x_adc` and `srdyo_o` is high for one cycle.
  - At most one pop per cycle; back-to-back pops are allowed.
  - Pop decisions use the count from the start of the cycle, so a push into an empty FIFO cannot pop in the same cycle.
- Reset mid-word or with the FIFO non-empty: partial word and all buffered words are discarded.
- Reset values: `x_adc`=0, `srdyo_o`=0, `overflow_o`=0, `frame_err_o`=0, `parity_err_o`=0, FSM=IDLE, FIFO empty.

## Timing
- Cycle L: the final bit of a word is sampled (edge at end of L).
- Cycle L+1: word written into the FIFO.
- Cycle L+2: earliest `srdyo_o`, reached when the FIFO was empty and `drdyi` is high.
- Sustained throughput is 1 word per FRAME_W valid bits. A new frame may begin on cycle L+1.
- `frame_err_o` and `parity_err_o` pulse one cycle after the offending bit is sampled.
- `overflow_o` rises on cycle L+1 of the dropped word.

## Configuration
- `ADC_PARITY_CHECK_EN` defined:
  - The frame carries `WORD_W`+1 bits; the last bit is even parity over all FRAME_W bits.
  - On mismatch the word is not pushed and `parity_err_o` pulses.
  - On match only the data bits are pushed.
- `ADC_PARITY_CHECK_EN` undefined: frame is `WORD_W` bits, no check, `parity_err_o` tied 0. The port list is identical in both builds.

## Structure
- Package `adc_framer_pkg`:
  - `WORD_W` default.
  - FSM state enum (IDLE, SHIFT).
  - Bit-count width constant, sized for `WORD_W`+1.
- Sub-module `sample_fifo`:
  - Synchronous FIFO with parameters `DEPTH` and `WORD_W`.
  - Ports: push, pop, din, dout, full, empty.
  - The framer owns all overflow and pop gating.

## Test plan
- Reset, then one frame `0x088888` with `drdyi`=1 → `srdyo_o` high exactly 2 cycles after the last bit, `x_adc`=`0x088888`; no flags.
- Five frames with `drdyi`=0 and `DEPTH`=4 → `overflow_o` rises on the fifth word. Then raise `drdyi` → four back-to-back strobes with the first four words in order; `overflow_o` stays 1.
- `sfi` reasserted at bit 10 of a frame, then a full frame `0x1FFFFF` → `frame_err_o` pulses once; only `0x1FFFFF` is output.
- Gaps: `sdi_vld` toggling 1-0-1 throughout frame `0x155555` → correct word, latency measured from the last valid bit.
- `GlobalReset` at bit 15 with 2 words buffered → all outputs 0 the next cycle; a following frame is output normally.
- `ADC_PARITY_CHECK_EN` build: frame with a wrong parity bit → `parity_err_o` pulses, no `srdyo_o`; the next correct frame passes.

Source files
------------

// File: rtl/adc_framer_pkg.sv
// adc_framer_pkg: shared constants and receive FSM state type for the ADC sample framer
package adc_framer_pkg;
    localparam int WORD_W_DEF = 21;
    localparam int CNT_W = $clog2(WORD_W_DEF + 2);
    typedef enum logic {IDLE, SHIFT} rx_state_t;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous word FIFO; the caller never pushes when full without a pop, nor pops when empty
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WORD_W = 21
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    assign full = cnt == CW'(DEPTH);
    assign empty = cnt == '0;
    assign dout = mem[rp];
    // pointer and occupancy tracking; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            wp <= push ? wp + AW'(1) : wp;
            rp <= pop ? rp + AW'(1) : rp;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
    // storage array, written without reset since occupancy alone defines validity
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end
endmodule

// File: rtl/adc_sample_framer.sv
// adc_sample_framer: deserializes the ADC bit stream into words and buffers them; ADC_PARITY_CHECK_EN adds an even-parity bit per frame
module adc_sample_framer
    import adc_framer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              GlobalReset,
    input  logic              sdi,
    input  logic              sdi_vld,
    input  logic              sfi,
    input  logic              drdyi,
    output logic [WORD_W-1:0] x_adc,
    output logic              srdyo_o,
    output logic              overflow_o,
    output logic              frame_err_o,
    output logic              parity_err_o
);
`ifdef ADC_PARITY_CHECK_EN
    localparam int FRAME_W = WORD_W + 1;
`else
    localparam int FRAME_W = WORD_W;
`endif
    rx_state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [FRAME_W-1:0] sh, sh_n;
    logic [WORD_W-1:0] word, dout;
    logic done, ferr, par_ok, push, pop, full, empty;
    // receive state, bit count and shift register
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state <= IDLE;
            cnt <= '0;
            sh <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            sh <= sh_n;
        end
    end
    // next state: sfi always restarts a frame; the word completes as its last bit is shifted in
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        sh_n = sh;
        done = 1'b0;
        ferr = 1'b0;
        if (sdi_vld && sfi) begin
            ferr = state == SHIFT;
            state_n = SHIFT;
            cnt_n = CNT_W'(1);
            sh_n = FRAME_W'(sdi);
        end else if (sdi_vld && state == SHIFT) begin
            sh_n = {sh[FRAME_W-2:0], sdi};
            cnt_n = cnt + CNT_W'(1);
            if (cnt == CNT_W'(FRAME_W - 1)) begin
                done = 1'b1;
                state_n = IDLE;
                cnt_n = '0;
            end
        end
    end
`ifdef ADC_PARITY_CHECK_EN
    assign word = sh_n[FRAME_W-1:1];
    assign par_ok = ~^sh_n;
`else
    assign word = sh_n;
    assign par_ok = 1'b1;
`endif
    assign pop = ~empty & drdyi;
    assign push = done & par_ok & (~full | pop);
    sample_fifo #(.DEPTH(DEPTH), .WORD_W(WORD_W)) u_fifo (
        .clk(clk),
        .rst(GlobalReset),
        .push(push),
        .pop(pop),
        .din(word),
        .dout(dout),
        .full(full),
        .empty(empty)
    );
    // output register, strobe and status flags
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            x_adc <= '0;
            srdyo_o <= 1'b0;
            overflow_o <= 1'b0;
            frame_err_o <= 1'b0;
            parity_err_o <= 1'b0;
        end else begin
            x_adc <= pop ? dout : x_adc;
            srdyo_o <= pop;
            overflow_o <= overflow_o | (done & par_ok & full & ~pop);
            frame_err_o <= ferr;
            parity_err_o <= done & ~par_ok;
        end
    end
endmodule
